wb_regfile_unit: RTL and testbench
==================================

// Module: wb_regfile_unit
// PURPOSE
//  Write-back stage: consumer end of the MEM/WB pipeline register. Takes the latched
//  memory data, ALU result, PC+imm, destination and write-back control, selects the
//  result, and commits it to the 64x32 register file. Serves two combinational read
//  ports to ID with same-cycle write bypass, and drives a WB forwarding bus to EX.
// PARAMETERS
//  DATA_W      32  datapath / register width
//  REG_AW      6   register index width (2**REG_AW registers)
//  CNT_W       32  retired-write counter width
// PORTS
//  clk          in   1       single clock; MEM/WB launches on negedge, this block commits on posedge
//  rst          in   1       asynchronous, active-low reset
//  memDataIn    in   DATA_W  load data from MEM/WB
//  aluResIn     in   DATA_W  ALU result from MEM/WB
//  pcPlusImmIn  in   DATA_W  PC+imm (link value) from MEM/WB
//  dstRegIn     in   REG_AW  destination register index
//  wbCtrlIn     in   3       [0]=regWrite, [2:1]=src: 00 ALU, 01 MEM, 10 PC+imm, 11 illegal
//  rdAddrA/B    in   REG_AW  ID read addresses
//  rdDataA/B    out  DATA_W  ID read data (combinational, bypassed)
//  fwdValid     out  1       WB result valid this cycle for forwarding
//  fwdReg       out  REG_AW  forwarded destination index
//  fwdData      out  DATA_W  forwarded value
//  wbCount      out  CNT_W   count of committed register writes
//  illegalSrc   out  1       sticky: a write was attempted with src=11
// BEHAVIOUR
//  - Reset (rst low, async): all 64 registers, wbCount, illegalSrc cleared to 0;
//    while low, fwdValid=0 and no commit occurs regardless of inputs.
//  - Select: wbData = src 00 ? aluResIn : 01 ? memDataIn : 10 ? pcPlusImmIn : 0.
//  - wbEn = regWrite && (src != 11). Combinational, from current inputs.
//  - Commit: on posedge clk, if wbEn, reg[dstRegIn] <= wbData. One commit per cycle;
//    latency from MEM/WB negedge launch to architectural state = half cycle.
//  - All 64 registers writable (no hardwired zero).
//  - Read ports: rdDataX = (wbEn && rdAddrX==dstRegIn) ? wbData : reg[rdAddrX].
//    Both ports may read the same register; both bypass independently.
//  - Forward bus: fwdValid=wbEn, fwdReg=dstRegIn, fwdData=wbData; when fwdValid=0
//    fwdReg and fwdData drive 0.
//  - wbCount increments by 1 on each posedge with wbEn; wraps 2**CNT_W-1 -> 0.
//  - illegalSrc sets on posedge when regWrite && src==11; no register write then;
//    cleared only by reset.
//  - regWrite=0: no write, no count, no bypass, regardless of src/dstReg.
//  - Reset asserted mid-cycle with wbEn high: the pending write is dropped.
//  - Back-to-back writes to same register: later cycle wins; reads between see bypass.
// STRUCTURE
//  - Shared package: wbCtrl bit positions, src encodings (WB_SRC_ALU/MEM/PC/ILL),
//    DATA_W/REG_AW defaults, common with the MEM/WB register and control decoder.
//  - One sub-module: wb_result_mux (combinational src select + wbEn).
//    Register array, bypass, counter, sticky flag live in the top.
// TESTING
//  1. rst low with regWrite=1 -> no commit; after release all rdData=0, wbCount=0.
//  2. wbCtrl=3'b001, dst=5, alu=0xDEADBEEF -> reg5=0xDEADBEEF next posedge; rdAddrA=5
//     returns it same cycle (bypass) and after; fwdValid=1, fwdReg=5; wbCount=1.
//  3. wbCtrl=3'b011 mem=0x1234 dst=63, then 3'b101 pc=0x40 dst=63 -> reg63=0x40 final,
//     rdDataB shows 0x1234 then 0x40; wbCount +2.
//  4. wbCtrl=3'b111 dst=7 alu=0x55 -> reg7 unchanged (0), illegalSrc=1, fwdValid=0,
//     count unchanged; illegalSrc stays 1 until rst.
//  5. wbCtrl=3'b010 (regWrite=0) dst=2 -> no write, fwdValid=0, fwdReg/fwdData=0.
//  6. Preload wbCount to 2**CNT_W-1 (CNT_W=4 build) + one write -> wraps to 0.

Source files
------------

// File: rtl/wb_regfile_unit_pkg.sv
// Shared write-back definitions: control-word bit positions, result-source
// encodings and datapath defaults used by MEM/WB, the decoder and this stage.
package wb_regfile_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 6;
    localparam int CNT_W_DEF  = 32;

    localparam int WB_CTRL_W       = 3;
    localparam int WB_CTRL_WE      = 0;
    localparam int WB_CTRL_SRC_LSB = 1;
    localparam int WB_CTRL_SRC_MSB = 2;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'b00,
        WB_SRC_MEM = 2'b01,
        WB_SRC_PC  = 2'b10,
        WB_SRC_ILL = 2'b11
    } wb_src_e;

endpackage

// File: rtl/wb_regfile_unit_if.sv
// Write-back stage bus: MEM/WB inputs, ID read ports, EX forwarding and status.
interface wb_regfile_unit_if
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic [DATA_W-1:0]    memDataIn;
    logic [DATA_W-1:0]    aluResIn;
    logic [DATA_W-1:0]    pcPlusImmIn;
    logic [REG_AW-1:0]    dstRegIn;
    logic [WB_CTRL_W-1:0] wbCtrlIn;
    logic [REG_AW-1:0]    rdAddrA;
    logic [REG_AW-1:0]    rdAddrB;
    logic [DATA_W-1:0]    rdDataA;
    logic [DATA_W-1:0]    rdDataB;
    logic                 fwdValid;
    logic [REG_AW-1:0]    fwdReg;
    logic [DATA_W-1:0]    fwdData;
    logic [CNT_W-1:0]     wbCount;
    logic                 illegalSrc;

    modport master (
        output memDataIn, aluResIn, pcPlusImmIn, dstRegIn, wbCtrlIn, rdAddrA, rdAddrB,
        input  rdDataA, rdDataB, fwdValid, fwdReg, fwdData, wbCount, illegalSrc
    );

    modport slave (
        input  memDataIn, aluResIn, pcPlusImmIn, dstRegIn, wbCtrlIn, rdAddrA, rdAddrB,
        output rdDataA, rdDataB, fwdValid, fwdReg, fwdData, wbCount, illegalSrc
    );

endinterface

// File: rtl/wb_regfile_unit_result_mux.sv
// Write-back result select: picks ALU / load / link value and decides whether
// the control word is a real register write or an illegal-source attempt.
module wb_result_mux
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [WB_CTRL_W-1:0] wb_ctrl,
    input  logic [DATA_W-1:0]    alu_res,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [DATA_W-1:0]    pc_plus_imm,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_en,
    output logic                 illegal_wr
);

    wb_src_e src;
    logic    reg_write;

    assign src       = wb_src_e'(wb_ctrl[WB_CTRL_SRC_MSB:WB_CTRL_SRC_LSB]);
    assign reg_write = wb_ctrl[WB_CTRL_WE];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wb_data = '0;
        case (src)
            WB_SRC_ALU: wb_data = alu_res;
            WB_SRC_MEM: wb_data = mem_data;
            WB_SRC_PC:  wb_data = pc_plus_imm;
            default:    wb_data = '0;
        endcase
        wb_en      = reg_write && (src != WB_SRC_ILL);
        illegal_wr = reg_write && (src == WB_SRC_ILL);
    end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage top: commits the selected result into the register file,
// serves two bypassed read ports and drives the WB forwarding bus.
module wb_regfile_unit
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_unit_if.slave   bus
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] wb_data;
    logic              wb_req_en;
    logic              illegal_req;
    logic              wb_en;
    logic              illegal_wr;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [CNT_W-1:0]  wb_count_d, wb_count_q;
    logic              illegal_d, illegal_q;

    wb_result_mux #(.DATA_W(DATA_W)) u_result_mux (
        .wb_ctrl     (bus.wbCtrlIn),
        .alu_res     (bus.aluResIn),
        .mem_data    (bus.memDataIn),
        .pc_plus_imm (bus.pcPlusImmIn),
        .wb_data     (wb_data),
        .wb_en       (wb_req_en),
        .illegal_wr  (illegal_req)
    );

    // Reset is asynchronous, so gate the request with it to suppress forwarding too.
    assign wb_en      = wb_req_en && rst;
    assign illegal_wr = illegal_req && rst;

    always_comb begin
        wb_count_d = wb_count_q + CNT_W'(wb_en);
        illegal_d  = illegal_q || illegal_wr;
    end

    // NOTE: the register file is reset because the architecture defines every register as 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[bus.dstRegIn] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            wb_count_q <= wb_count_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        bus.rdDataA    = (wb_en && (bus.rdAddrA == bus.dstRegIn)) ? wb_data : regs_q[bus.rdAddrA];
        bus.rdDataB    = (wb_en && (bus.rdAddrB == bus.dstRegIn)) ? wb_data : regs_q[bus.rdAddrB];
        bus.fwdValid   = wb_en;
        bus.fwdReg     = wb_en ? bus.dstRegIn : '0;
        bus.fwdData    = wb_en ? wb_data : '0;
        bus.wbCount    = wb_count_q;
        bus.illegalSrc = illegal_q;
    end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit: table of per-cycle vectors plus hand-written
// reset, mid-cycle reset and counter-wrap sequences (second instance has CNT_W=4).
module tb_wb_regfile_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    wb_regfile_unit_if #(.DATA_W(32), .REG_AW(6), .CNT_W(32)) bus ();
    wb_regfile_unit_if #(.DATA_W(32), .REG_AW(6), .CNT_W(4))  bus4 ();

    wb_regfile_unit #(.DATA_W(32), .REG_AW(6), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wb_regfile_unit #(.DATA_W(32), .REG_AW(6), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    assign bus4.memDataIn   = bus.memDataIn;
    assign bus4.aluResIn    = bus.aluResIn;
    assign bus4.pcPlusImmIn = bus.pcPlusImmIn;
    assign bus4.dstRegIn    = bus.dstRegIn;
    assign bus4.wbCtrlIn    = bus.wbCtrlIn;
    assign bus4.rdAddrA     = bus.rdAddrA;
    assign bus4.rdAddrB     = bus.rdAddrB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [5:0]  dst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_fv;
        logic [5:0]  exp_fr;
        logic [31:0] exp_fd;
        logic [31:0] exp_cnt;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] ctrl, input logic [5:0] dst, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc,
                         input logic [5:0] ra, input logic [5:0] rb);
        bus.wbCtrlIn    = ctrl;
        bus.dstRegIn    = dst;
        bus.aluResIn    = alu;
        bus.memDataIn   = mem;
        bus.pcPlusImmIn = pc;
        bus.rdAddrA     = ra;
        bus.rdAddrB     = rb;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          ctrl    dst    alu           mem           pc           ra     rb     exp_a         exp_b         fv    fr     fd            cnt ill
        vecs[0]  = '{3'b001, 6'd5,  32'hDEADBEEF, 32'h0,        32'h0,       6'd5,  6'd6,  32'hDEADBEEF, 32'h0,        1'b1, 6'd5,  32'hDEADBEEF, 1,  1'b0};
        vecs[1]  = '{3'b000, 6'd5,  32'h11,       32'h22,       32'h33,      6'd5,  6'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 6'd0,  32'h0,        1,  1'b0};
        vecs[2]  = '{3'b011, 6'd63, 32'h99,       32'h1234,     32'h77,      6'd5,  6'd63, 32'hDEADBEEF, 32'h1234,     1'b1, 6'd63, 32'h1234,     2,  1'b0};
        vecs[3]  = '{3'b101, 6'd63, 32'h99,       32'h1234,     32'h40,      6'd63, 6'd63, 32'h40,       32'h40,       1'b1, 6'd63, 32'h40,       3,  1'b0};
        vecs[4]  = '{3'b000, 6'd63, 32'h0,        32'h0,        32'h0,       6'd63, 6'd63, 32'h40,       32'h40,       1'b0, 6'd0,  32'h0,        3,  1'b0};
        vecs[5]  = '{3'b111, 6'd7,  32'h55,       32'h66,       32'h88,      6'd7,  6'd7,  32'h0,        32'h0,        1'b0, 6'd0,  32'h0,        3,  1'b1};
        vecs[6]  = '{3'b000, 6'd7,  32'h55,       32'h0,        32'h0,       6'd7,  6'd63, 32'h0,        32'h40,       1'b0, 6'd0,  32'h0,        3,  1'b1};
        vecs[7]  = '{3'b010, 6'd2,  32'h77,       32'h88,       32'h99,      6'd2,  6'd2,  32'h0,        32'h0,        1'b0, 6'd0,  32'h0,        3,  1'b1};
        vecs[8]  = '{3'b001, 6'd0,  32'hA5A50001, 32'h0,        32'h0,       6'd0,  6'd1,  32'hA5A50001, 32'h0,        1'b1, 6'd0,  32'hA5A50001, 4,  1'b1};
        vecs[9]  = '{3'b000, 6'd0,  32'h0,        32'h0,        32'h0,       6'd0,  6'd2,  32'hA5A50001, 32'h0,        1'b0, 6'd0,  32'h0,        4,  1'b1};
        vecs[10] = '{3'b100, 6'd0,  32'h0,        32'h0,        32'h123,     6'd0,  6'd5,  32'hA5A50001, 32'hDEADBEEF, 1'b0, 6'd0,  32'h0,        4,  1'b1};

        // Reset held with a live write request: nothing may commit or forward.
        rst = 1'b0;
        drive(3'b001, 6'd5, 32'hDEADBEEF, 32'h0, 32'h0, 6'd5, 6'd5);
        repeat (2) @(posedge clk);
        #1;
        check("rst_fwd_valid", 64'(bus.fwdValid), 64'd0);
        check("rst_rd_a_no_bypass", 64'(bus.rdDataA), 64'd0);
        check("rst_fwd_data", 64'(bus.fwdData), 64'd0);
        @(negedge clk);
        drive(3'b000, 6'd5, 32'h0, 32'h0, 32'h0, 6'd5, 6'd63);
        rst = 1'b1;
        #1;
        check("post_rst_rd_a", 64'(bus.rdDataA), 64'd0);
        check("post_rst_rd_b", 64'(bus.rdDataB), 64'd0);
        check("post_rst_count", 64'(bus.wbCount), 64'd0);
        check("post_rst_illegal", 64'(bus.illegalSrc), 64'd0);

        // Table: drive on negedge (MEM/WB launch), check comb mid-cycle, state after posedge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].dst, vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].ra, vecs[i].rb);
            #1;
            check($sformatf("v%0d_rd_a", i), 64'(bus.rdDataA), 64'(vecs[i].exp_a));
            check($sformatf("v%0d_rd_b", i), 64'(bus.rdDataB), 64'(vecs[i].exp_b));
            check($sformatf("v%0d_fwd_valid", i), 64'(bus.fwdValid), 64'(vecs[i].exp_fv));
            check($sformatf("v%0d_fwd_reg", i), 64'(bus.fwdReg), 64'(vecs[i].exp_fr));
            check($sformatf("v%0d_fwd_data", i), 64'(bus.fwdData), 64'(vecs[i].exp_fd));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), 64'(bus.wbCount), 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_count4", i), 64'(bus4.wbCount), 64'(vecs[i].exp_cnt[3:0]));
            check($sformatf("v%0d_illegal", i), 64'(bus.illegalSrc), 64'(vecs[i].exp_ill));
        end

        // Reset asserted mid-cycle while a write is pending: write dropped, all state cleared.
        @(negedge clk);
        drive(3'b001, 6'd10, 32'hFFFF0000, 32'h0, 32'h0, 6'd10, 6'd63);
        #1;
        check("mid_pre_bypass", 64'(bus.rdDataA), 64'hFFFF0000);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_fwd_valid", 64'(bus.fwdValid), 64'd0);
        check("mid_rst_reg63_cleared", 64'(bus.rdDataB), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(3'b000, 6'd10, 32'h0, 32'h0, 32'h0, 6'd10, 6'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_reg10", 64'(bus.rdDataA), 64'd0);
        check("mid_rst_reg0", 64'(bus.rdDataB), 64'd0);
        check("mid_rst_count", 64'(bus.wbCount), 64'd0);
        check("mid_rst_illegal_cleared", 64'(bus.illegalSrc), 64'd0);

        // Sixteen writes: 4-bit counter passes 15 and wraps to 0; 32-bit reaches 16.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(3'b001, 6'(i), 32'(i * 3), 32'h0, 32'h0, 6'd0, 6'd0);
            @(posedge clk);
            #1;
            if (i == 14) check("wrap_count4_max", 64'(bus4.wbCount), 64'd15);
        end
        check("wrap_count4_zero", 64'(bus4.wbCount), 64'd0);
        check("wrap_count32", 64'(bus.wbCount), 64'd16);
        @(negedge clk);
        drive(3'b000, 6'd0, 32'h0, 32'h0, 32'h0, 6'd15, 6'd3);
        #1;
        check("wrap_reg15", 64'(bus.rdDataA), 64'd45);
        check("wrap_reg3", 64'(bus.rdDataB), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
